// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst-holding round-robin arbiter for a shared PE FIFO write port.
// Define ARB_FIXED_PRIO_EN to select lowest-index-first arbitration instead of round-robin.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  input  logic                          full_flag,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          wr_request,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          busy
);

  // state | meaning
  // IDLE  | no grant held; arbitrate among req at the next negedge
  // GRANT | one source owns the write port until burst end or req drop

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     last_winner_q, last_winner_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 accept;
  logic                 beat_last;
  logic                 release_g;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] cand;

  // Search starts one past the previous winner; modulo keeps the wrap exact for non-power-of-two counts.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_winner_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  always_comb begin
    wr_request = (state_q == GRANT) && |(req & grant_q);
    accept     = wr_request && !full_flag;
    ack        = {NUM_REQ{accept}} & grant_q;
    wr_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_q == GRANT) && (gidx_q == IDX_W'(i)))
        wr_data = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign beat_last = (beat_cnt_q == CNT_WIDTH'(BURST_LEN - 1));
  assign release_g = (accept && beat_last) || !req[gidx_q];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_winner_d = last_winner_q;
    beat_cnt_d    = beat_cnt_q;
    busy_d        = busy_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          grant_d    = NUM_REQ'(1) << win_idx;
          gidx_d     = win_idx;
          beat_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      GRANT: begin
        if (accept)
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        // No re-arbitration on the release edge: an IDLE cycle always separates grants.
        if (release_g) begin
          state_d       = IDLE;
          grant_d       = '0;
          last_winner_d = gidx_q;
          busy_d        = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      last_winner_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      last_winner_q <= last_winner_d;
      beat_cnt_q    <= beat_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule
